// File: rtl/fetch.sv
// -----------------------------------------------------------------------------
// fetch
//
// Instruction-fetch stage of the RV32I_Zicsr pipeline. Keeps the program
// counter, issues one instruction-memory request at a time and registers each
// returned word together with its PC for decode. A one-entry skid buffer
// absorbs a response that lands while decode is stalled, and redirects
// (branch, jump, trap) squash any request still in flight.
//
// Optional feature macro: FETCH_MISALIGN_TRAP_EN
//   When defined, a misaligned redirect target raises or_misalign and parks
//   the stage in HALT until an aligned redirect or reset. When undefined the
//   low two bits of the redirect target are simply dropped.
//
// Parameters
//   XLEN         data/address width
//   RESET_PC     first PC fetched after reset
//
// Ports
//   i_clk          clock, all state on rising edge
//   i_rst_n        synchronous active-low reset
//   o_imem_req     fetch request valid
//   o_imem_addr    fetch address
//   i_imem_ack     response valid (same cycle as request or later)
//   i_imem_data    instruction word, meaningful with i_imem_ack
//   i_stall        decode cannot accept, hold outputs
//   i_flush        redirect request (highest priority)
//   i_redirect_pc  redirect target, sampled with i_flush
//   or_inst        registered instruction to decode
//   or_pc          registered PC of or_inst
//   or_valid       or_inst is a real fetched instruction
//   or_misalign    misaligned redirect flag (macro builds only)
// -----------------------------------------------------------------------------
module fetch #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    output logic            o_imem_req,
    output logic [XLEN-1:0] o_imem_addr,
    input  logic            i_imem_ack,
    input  logic [XLEN-1:0] i_imem_data,
    input  logic            i_stall,
    input  logic            i_flush,
    input  logic [XLEN-1:0] i_redirect_pc,
    output logic [XLEN-1:0] or_inst,
    output logic [XLEN-1:0] or_pc,
    output logic            or_valid
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    output logic            or_misalign
`endif
);

    // addi x0, x0, 0 -- decode sees this whenever nothing real is delivered
    localparam logic [XLEN-1:0] NOP = XLEN'(32'h0000_0013);

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_KILL  = 2'd1
`ifdef FETCH_MISALIGN_TRAP_EN
        ,
        ST_HALT  = 2'd2
`endif
    } state_t;

    state_t          state_q, state_d;
    logic            run_q;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] kill_pc_q, kill_pc_d;
    logic            skid_valid_q, skid_valid_d;
    logic [XLEN-1:0] skid_inst_q, skid_inst_d;
    logic [XLEN-1:0] skid_pc_q, skid_pc_d;
    logic [XLEN-1:0] inst_d;
    logic [XLEN-1:0] out_pc_d;
    logic            valid_d;
    logic            ack_ok;
    logic [XLEN-1:0] target_pc;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic            misalign_d;
    logic            target_misaligned;
`endif

    // run_q holds requests off for the first cycle after reset, so the first
    // request goes out in the cycle that starts at the first non-reset edge.
    assign ack_ok = i_imem_ack & run_q;

`ifdef FETCH_MISALIGN_TRAP_EN
    assign target_pc         = i_redirect_pc;
    assign target_misaligned = (i_redirect_pc[1:0] != 2'b00);
`else
    assign target_pc         = i_redirect_pc & ~XLEN'(3);
`endif

    // State and datapath registers.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q      <= ST_FETCH;
            run_q        <= 1'b0;
            pc_q         <= RESET_PC;
            kill_pc_q    <= RESET_PC;
            skid_valid_q <= 1'b0;
            skid_inst_q  <= NOP;
            skid_pc_q    <= '0;
            or_inst      <= NOP;
            or_pc        <= '0;
            or_valid     <= 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
            or_misalign  <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            run_q        <= 1'b1;
            pc_q         <= pc_d;
            kill_pc_q    <= kill_pc_d;
            skid_valid_q <= skid_valid_d;
            skid_inst_q  <= skid_inst_d;
            skid_pc_q    <= skid_pc_d;
            or_inst      <= inst_d;
            or_pc        <= out_pc_d;
            or_valid     <= valid_d;
`ifdef FETCH_MISALIGN_TRAP_EN
            or_misalign  <= misalign_d;
`endif
        end
    end

    // Request generation, next-state and next-output logic.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        kill_pc_d    = kill_pc_q;
        skid_valid_d = skid_valid_q;
        skid_inst_d  = skid_inst_q;
        skid_pc_d    = skid_pc_q;
        inst_d       = or_inst;
        out_pc_d     = or_pc;
        valid_d      = or_valid;
`ifdef FETCH_MISALIGN_TRAP_EN
        misalign_d   = or_misalign;
`endif
        o_imem_req   = 1'b0;
        o_imem_addr  = pc_q;

        // The request only depends on registered state, so the address stays
        // put until the ack (pc moves only on ack or flush).
        case (state_q)
            ST_FETCH: o_imem_req = run_q & ~skid_valid_q;
            ST_KILL: begin
                o_imem_req  = 1'b1;
                o_imem_addr = kill_pc_q;
            end
            default: o_imem_req = 1'b0;
        endcase

        if (i_flush) begin
            pc_d         = target_pc;
            skid_valid_d = 1'b0;
            inst_d       = NOP;
            out_pc_d     = '0;
            valid_d      = 1'b0;
            // A request the memory has seen but not answered must be drained
            // before fetching again; remember its address to keep it stable.
            if (o_imem_req && !i_imem_ack) begin
                state_d   = ST_KILL;
                kill_pc_d = o_imem_addr;
            end else begin
                state_d   = ST_FETCH;
            end
`ifdef FETCH_MISALIGN_TRAP_EN
            if (target_misaligned) begin
                state_d    = ST_HALT;
                misalign_d = 1'b1;
                out_pc_d   = i_redirect_pc;
            end else begin
                misalign_d = 1'b0;
            end
`endif
        end else begin
            case (state_q)
                ST_FETCH: begin
                    if (ack_ok) begin
                        pc_d = pc_q + XLEN'(4);
                        if (i_stall) begin
                            skid_valid_d = 1'b1;
                            skid_inst_d  = i_imem_data;
                            skid_pc_d    = pc_q;
                        end else if (skid_valid_q) begin
                            // Older buffered word goes first, new one refills.
                            inst_d      = skid_inst_q;
                            out_pc_d    = skid_pc_q;
                            valid_d     = 1'b1;
                            skid_inst_d = i_imem_data;
                            skid_pc_d   = pc_q;
                        end else begin
                            inst_d   = i_imem_data;
                            out_pc_d = pc_q;
                            valid_d  = 1'b1;
                        end
                    end else if (!i_stall) begin
                        if (skid_valid_q) begin
                            inst_d       = skid_inst_q;
                            out_pc_d     = skid_pc_q;
                            valid_d      = 1'b1;
                            skid_valid_d = 1'b0;
                        end else begin
                            inst_d   = NOP;
                            out_pc_d = '0;
                            valid_d  = 1'b0;
                        end
                    end
                end
                ST_KILL: begin
                    if (ack_ok) begin
                        state_d = ST_FETCH;
                    end
                    if (!i_stall) begin
                        inst_d   = NOP;
                        out_pc_d = '0;
                        valid_d  = 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: doc/fetch.md
# fetch

Instruction-fetch stage of the RV32I_Zicsr pipeline, sitting directly upstream of decode. It keeps the program counter and issues one instruction-memory request at a time. Each returned word is registered together with its PC as decode's `i_inst`/`i_pc`. It also handles back-pressure from the hazard unit through a one-entry skid buffer, and control-flow redirects (branch, jump, trap) by squashing in-flight fetches.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC fetched first after reset.
- `i_clk`  in  1  CPU clock; all state on rising edge.
- `i_rst_n`  in  1  reset. Synchronous, active-low.
- `o_imem_req`  out  1  instruction fetch request valid.
- `o_imem_addr`  out  `XLEN`  fetch address.
- `i_imem_ack`  in  1  response valid. May arrive in the request cycle or later.
- `i_imem_data`  in  `XLEN`  instruction word. Meaningful only when `i_imem_ack`=1.
- `i_stall`  in  1  decode cannot accept; hold outputs.
- `i_flush`  in  1  redirect request.
- `i_redirect_pc`  in  `XLEN`  redirect target, sampled when `i_flush`=1.
- `or_inst`  out  `XLEN`  registered instruction to decode.
- `or_pc`  out  `XLEN`  registered PC of `or_inst`.
- `or_valid`  out  1  `or_inst` is a real fetched instruction.
- `or_misalign`  out  1  only when `FETCH_MISALIGN_TRAP_EN` is defined (see Configuration).

## Operation
- **Reset values:**
  - `pc`=`RESET_PC`, state=FETCH, skid buffer empty.
  - `or_inst`=32'h0000_0013 (NOP, addi x0,x0,0), `or_pc`=0, `or_valid`=0, `or_misalign`=0.
- **Bubbles:**
  - Whenever no instruction is delivered and `i_stall`=0, outputs become NOP, `or_pc`=0, `or_valid`=0.
  - This lets decode, which has no valid input, decode a harmless instruction.
- **States:**
  - FETCH: `o_imem_req`=1 and `o_imem_addr`=`pc` unless the skid buffer is full.
  - KILL: `o_imem_req`=1 and address is held at the squashed PC until `i_imem_ack`. Data is discarded, then go to FETCH.
  - HALT: only with the macro; see Configuration.
- **Request protocol:**
  - The address is held stable while req=1 and no ack has arrived.
  - At most one request is outstanding.
- **Ack in FETCH, `i_stall`=0, no flush:**
  - If the buffer is empty: `or_inst`←data, `or_pc`←`pc`, `or_valid`←1, `pc`←`pc`+4 (mod 2^32, wraps silently).
  - If the buffer is full: the buffer drains to the outputs first, and the ack data refills the buffer.
- **Ack in FETCH with `i_stall`=1:**
  - Data and PC go into the skid buffer, and `pc`←`pc`+4.
  - `o_imem_req`=0 while the buffer is full.
  - Outputs hold.
- **Stall release:** in the first cycle with `i_stall`=0 and the buffer full, the buffer moves to the outputs and the buffer empties.
- **`i_stall`=1 without ack:** outputs hold, and the request stays asserted.
- **`i_flush`=1 has priority over everything:**
  - `pc`←`i_redirect_pc`, buffer cleared, outputs→NOP/`or_valid`=0 regardless of `i_stall`.
  - An ack in the same cycle is discarded.
  - If a request is outstanding and not acked this cycle, go to KILL; otherwise go to FETCH.
- **Redirect alignment:** without the macro, `i_redirect_pc[1:0]` is forced to 2'b00 when loaded into `pc`.
- **Flush in KILL:** `pc` is updated and the state stays in KILL.

## Timing
- Zero-wait memory (ack in the request cycle) with no stalls gives 1 instruction/cycle.
- `or_inst` is valid the edge after its ack.
- Reset deasserted before edge E0: the first request is in cycle E0→E1, and `or_pc`=`RESET_PC` is visible after E1.
- Flush sampled at edge N: the target is requested in cycle N→N+1, and `or_pc`=target is visible after N+1, assuming zero-wait and no KILL.
- KILL adds the remaining latency of the squashed request.
- `i_rst_n` low mid-request: all state is reset at that edge. The memory's pending ack is ignored because reset returns to FETCH, so the memory must also be reset.

## Configuration
- Macro: `FETCH_MISALIGN_TRAP_EN`.
- **Defined:**
  - The port `or_misalign` exists.
  - A flush with `i_redirect_pc[1:0]`≠0 sets `or_misalign`←1 and `or_pc`←the full target, with `or_inst`=NOP and `or_valid`=0, and enters HALT.
  - HALT has req=0 and outputs hold. It exits only on an aligned flush (clears `or_misalign`) or reset.
  - A misaligned flush while halted updates `or_pc` and stays in HALT.
- **Undefined:**
  - No port, no HALT.
  - Low bits are masked as described in Operation.

## Test plan
- **Reset, zero-wait memory:** memory returns words 0x1000_0093, 0x0010_8113, … with `RESET_PC`=0x0. Required: `or_pc` 0x0, 0x4, 0x8 on consecutive cycles, `or_valid`=1, and instructions matching in order.
- **Stall:** `i_stall`=1 for 3 cycles while an ack for PC 0x8 arrives. Required: outputs hold the PC 0x4 instruction, req drops after buffering, and PC 0x8 appears in the first cycle after release, then 0xC.
- **Flush during outstanding 3-cycle-latency request:** flush to 0x200 one cycle after the request for 0x10. Required: the 0x10 data is never output, the next valid `or_pc`=0x200, and NOP bubbles appear meanwhile.
- **Flush with same-cycle ack and `i_stall`=1:** required: data discarded, `or_valid`=0 next cycle, next fetch address 0x200.
- **Wrap:** `RESET_PC`=0xFFFF_FFFC. Required: `or_pc` 0xFFFF_FFFC, then 0x0000_0000.
- **Misaligned redirect:**
  - With the macro: flush to 0x202 gives `or_misalign`=1, `or_pc`=0x202, req=0. A following flush to 0x300 resumes fetch and clears `or_misalign`.
  - Without the macro: flush to 0x202 fetches 0x200.
